// File: rtl/obstacle_scroller_if.sv
// Obstacle pair handshake between the random generator (master) and the
// scrolling lane (slave).
//   pair  : [1] = head column, [0] = tail column
//   valid : pair holds a descriptor pair
//   req   : lane buffer is empty and can take a pair
interface obstacle_scroller_if #(
   parameter int unsigned OBJ_W = 24
);
   logic [1:0][OBJ_W-1:0] pair;
   logic                  valid;
   logic                  req;

   modport master (output pair, output valid, input req);
   modport slave  (input pair, input valid, output req);
endinterface

// File: rtl/obstacle_scroller.sv
// Scrolling obstacle lane. SLOTS columns shift one place toward the exit on
// every honoured step. Obstacle pairs arrive through a single-entry buffer.
// Each pair is inserted as two adjacent columns, followed by SPACING empty
// columns. The lane reports its front obstacle and a pulse for each occupied
// column that leaves, and keeps a saturating count of those columns.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_run           0 freezes the lane; a pair can still load into the buffer
//   i_step          one-cycle advance request
//   pair_if         pair/valid/req handshake (slave side)
//   o_slots, o_occ  column contents and occupied flags (slot 0 = entry)
//   o_front         highest-index occupied column, 0 when the lane is empty
//   o_front_valid   any column occupied
//   o_passed        one-cycle pulse when an occupied column leaves
//   o_score         count of columns that left, saturating
module obstacle_scroller #(
   parameter int unsigned SLOTS   = 8,
   parameter int unsigned OBJ_W   = 24,
   parameter int unsigned H_W     = 5,
   parameter int unsigned SPACING = 4,
   parameter int unsigned SCORE_W = 8
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_run,
   input  logic                        i_step,
   obstacle_scroller_if.slave          pair_if,
   output logic [SLOTS-1:0][OBJ_W-1:0] o_slots,
   output logic [SLOTS-1:0]            o_occ,
   output logic [OBJ_W-1:0]            o_front,
   output logic                        o_front_valid,
   output logic                        o_passed,
   output logic [SCORE_W-1:0]          o_score
);

   localparam int unsigned GAP_W = (SPACING > 0) ? $clog2(SPACING + 1) : 1;

   if (SLOTS < 3 || H_W > OBJ_W) begin : g_param_check
      $error("obstacle_scroller: needs SLOTS >= 3 and H_W <= OBJ_W");
   end

   typedef enum logic [1:0] {S_WAIT, S_TAIL, S_GAP} state_t;

   state_t                      r_state;
   logic [SLOTS-1:0][OBJ_W-1:0] r_slots;
   logic [SLOTS-1:0]            r_occ;
   logic [1:0][OBJ_W-1:0]       r_buf;
   logic                        r_buf_full;
   logic [GAP_W-1:0]            r_gap_cnt;
   logic                        r_passed;
   logic [SCORE_W-1:0]          r_score;
   logic                        w_adv;
   logic [OBJ_W-1:0]            w_front;

   assign w_adv = i_run & i_step;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_WAIT;
         r_slots    <= '0;
         r_occ      <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_gap_cnt  <= '0;
         r_passed   <= 1'b0;
         r_score    <= '0;
      end else begin
         // The buffer is full throughout TAIL, so this load can never collide
         // with the TAIL clear below.
         if (pair_if.valid && !r_buf_full) begin
            r_buf      <= pair_if.pair;
            r_buf_full <= 1'b1;
         end

         if (w_adv) begin
            r_slots[SLOTS-1:1] <= r_slots[SLOTS-2:0];
            r_occ[SLOTS-1:1]   <= r_occ[SLOTS-2:0];
            r_passed           <= r_occ[SLOTS-1];
            if (r_occ[SLOTS-1] && (r_score != '1)) begin
               r_score <= r_score + 1'b1;
            end

            case (r_state)
               S_WAIT: begin
                  // Decision uses the registered full flag: a pair loaded in
                  // this same cycle only becomes the head on the next advance.
                  if (r_buf_full) begin
                     r_slots[0] <= r_buf[1];
                     r_occ[0]   <= 1'b1;
                     r_state    <= S_TAIL;
                  end else begin
                     r_slots[0] <= '0;
                     r_occ[0]   <= 1'b0;
                  end
               end
               S_TAIL: begin
                  r_slots[0] <= r_buf[0];
                  r_occ[0]   <= 1'b1;
                  r_buf_full <= 1'b0;
                  if (SPACING > 0) begin
                     r_gap_cnt <= GAP_W'(SPACING);
                     r_state   <= S_GAP;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
               S_GAP: begin
                  r_slots[0] <= '0;
                  r_occ[0]   <= 1'b0;
                  r_gap_cnt  <= r_gap_cnt - 1'b1;
                  if (r_gap_cnt == GAP_W'(1)) begin
                     r_state <= S_WAIT;
                  end
               end
               default: r_state <= S_WAIT;
            endcase
         end else begin
            r_passed <= 1'b0;
         end
      end
   end

   // Ascending scan so the highest occupied index wins.
   always_comb begin
      w_front = '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
         if (r_occ[i]) begin
            w_front = r_slots[i];
         end
      end
   end

   assign pair_if.req   = !r_buf_full;
   assign o_slots       = r_slots;
   assign o_occ         = r_occ;
   assign o_front       = w_front;
   assign o_front_valid = |r_occ;
   assign o_passed      = r_passed;
   assign o_score       = r_score;

endmodule

// File: tb/tb_obstacle_scroller.sv
module tb_obstacle_scroller;

   logic clk = 1'b0;
   logic reset, run, step, valid;
   logic [1:0][23:0] pair;

   logic [7:0][23:0] slots_a, slots_b;
   logic [7:0]       occ_a, occ_b;
   logic [23:0]      front_a, front_b;
   logic             fv_a, fv_b, passed_a, passed_b;
   logic [7:0]       score_a;
   logic [1:0]       score_b;

   int checks   = 0;
   int failures = 0;

   localparam logic [23:0] A = 24'hA00011, B = 24'hB00012, C = 24'hC00013,
                           D = 24'hD00014, E = 24'hE00015, F = 24'hF00016,
                           G = 24'h123417, H = 24'h456718;

   always #5 clk = ~clk;

   obstacle_scroller_if #(.OBJ_W(24)) ifa ();
   obstacle_scroller_if #(.OBJ_W(24)) ifb ();
   assign ifa.pair  = pair;
   assign ifa.valid = valid;
   assign ifb.pair  = pair;
   assign ifb.valid = valid;

   obstacle_scroller #(.SLOTS(8), .OBJ_W(24), .H_W(5), .SPACING(4), .SCORE_W(8)) u_dut_a (
      .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step), .pair_if(ifa.slave),
      .o_slots(slots_a), .o_occ(occ_a), .o_front(front_a), .o_front_valid(fv_a),
      .o_passed(passed_a), .o_score(score_a));

   obstacle_scroller #(.SLOTS(8), .OBJ_W(24), .H_W(5), .SPACING(4), .SCORE_W(2)) u_dut_b (
      .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step), .pair_if(ifb.slave),
      .o_slots(slots_b), .o_occ(occ_b), .o_front(front_b), .o_front_valid(fv_b),
      .o_passed(passed_b), .o_score(score_b));

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic adv();
      step = 1'b1;
      cyc();
      step = 1'b0;
   endtask

   task automatic load(input logic [23:0] head, input logic [23:0] tail);
      pair  = {head, tail};
      valid = 1'b1;
      cyc();
      valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; step = 1'b1; valid = 1'b1; run = 1'b1; pair = {A, B};
      cyc(); cyc();
      reset = 1'b0; step = 1'b0; valid = 1'b0;
      checks++; if (slots_a !== '0) begin failures++; $display("FAIL reset_slots got=%h want=0", slots_a); end
      checks++; if (occ_a !== 8'h00) begin failures++; $display("FAIL reset_occ got=%b want=00000000", occ_a); end
      checks++; if (score_a !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d want=0", score_a); end
      checks++; if (ifa.req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b want=1", ifa.req); end
      checks++; if (passed_a !== 1'b0) begin failures++; $display("FAIL reset_passed got=%b want=0", passed_a); end
      checks++; if (front_a !== 24'h0 || fv_a !== 1'b0) begin failures++; $display("FAIL reset_front got=%h/%b want=0/0", front_a, fv_a); end
   endtask

   task automatic test_insert();
      do_reset();
      load(A, B);
      checks++; if (ifa.req !== 1'b0) begin failures++; $display("FAIL ins_req_full got=%b want=0", ifa.req); end
      adv();
      checks++; if (slots_a[0] !== A || occ_a !== 8'b0000_0001) begin failures++; $display("FAIL ins_adv1 got=%h/%b want=%h/00000001", slots_a[0], occ_a, A); end
      adv();
      checks++; if (slots_a[1] !== A || slots_a[0] !== B || occ_a !== 8'b0000_0011) begin failures++; $display("FAIL ins_adv2 got=%h,%h/%b want=%h,%h/00000011", slots_a[1], slots_a[0], occ_a, A, B); end
      checks++; if (ifa.req !== 1'b1) begin failures++; $display("FAIL ins_req_free got=%b want=1", ifa.req); end
      // Load right after TAIL; it must wait out the four gap columns.
      load(C, D);
      for (int k = 0; k < 4; k++) adv();
      checks++; if (occ_a !== 8'b0011_0000 || slots_a[5] !== A || slots_a[4] !== B) begin failures++; $display("FAIL ins_gap got=%b %h,%h want=00110000 %h,%h", occ_a, slots_a[5], slots_a[4], A, B); end
      checks++; if (front_a !== A || fv_a !== 1'b1) begin failures++; $display("FAIL ins_front got=%h/%b want=%h/1", front_a, fv_a, A); end
      adv();
      checks++; if (occ_a !== 8'b0110_0001 || slots_a[0] !== C) begin failures++; $display("FAIL ins_next_head got=%b %h want=01100001 %h", occ_a, slots_a[0], C); end
   endtask

   task automatic test_starve();
      do_reset();
      for (int k = 0; k < 3; k++) adv();
      checks++; if (occ_a !== 8'h00 || slots_a !== '0) begin failures++; $display("FAIL starve_empty got=%b want=00000000", occ_a); end
      // Load and advance in the same cycle: head is not yet eligible.
      pair = {C, D}; valid = 1'b1; step = 1'b1;
      cyc();
      valid = 1'b0; step = 1'b0;
      checks++; if (occ_a !== 8'h00 || ifa.req !== 1'b0) begin failures++; $display("FAIL starve_same_cycle got=%b req=%b want=00000000 req=0", occ_a, ifa.req); end
      adv();
      checks++; if (slots_a[0] !== C || occ_a !== 8'b0000_0001) begin failures++; $display("FAIL starve_head got=%h/%b want=%h/00000001", slots_a[0], occ_a, C); end
      adv();
      checks++; if (slots_a[1] !== C || slots_a[0] !== D || occ_a !== 8'b0000_0011) begin failures++; $display("FAIL starve_tail got=%h,%h/%b want=%h,%h/00000011", slots_a[1], slots_a[0], occ_a, C, D); end
   endtask

   task automatic test_pass();
      int npass;
      npass = 0;
      do_reset();
      load(E, F);
      for (int k = 0; k < 8; k++) begin
         adv();
         if (passed_a) npass++;
      end
      checks++; if (npass != 0) begin failures++; $display("FAIL pass_early got=%0d want=0", npass); end
      checks++; if (occ_a !== 8'b1100_0000 || slots_a[7] !== E || slots_a[6] !== F || front_a !== E) begin failures++; $display("FAIL pass_at_exit got=%b %h,%h front=%h want=11000000 %h,%h front=%h", occ_a, slots_a[7], slots_a[6], front_a, E, F, E); end
      adv();
      checks++; if (passed_a !== 1'b1 || score_a !== 8'd1 || front_a !== F || occ_a !== 8'b1000_0000) begin failures++; $display("FAIL pass_first got=p%b s%0d f=%h o=%b want=p1 s1 f=%h o=10000000", passed_a, score_a, front_a, occ_a, F); end
      cyc();
      checks++; if (passed_a !== 1'b0 || score_a !== 8'd1) begin failures++; $display("FAIL pass_pulse_width got=p%b s%0d want=p0 s1", passed_a, score_a); end
      adv();
      checks++; if (passed_a !== 1'b1 || score_a !== 8'd2 || fv_a !== 1'b0 || front_a !== 24'h0) begin failures++; $display("FAIL pass_second got=p%b s%0d fv%b f=%h want=p1 s2 fv0 f=0", passed_a, score_a, fv_a, front_a); end
      adv();
      checks++; if (passed_a !== 1'b0 || score_a !== 8'd2 || score_b !== 2'd2) begin failures++; $display("FAIL pass_after got=p%b s%0d sb%0d want=p0 s2 sb2", passed_a, score_a, score_b); end
   endtask

   task automatic test_saturate();
      int npass_b;
      npass_b = 0;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         load(24'h000100 + 24'(p), 24'h000200 + 24'(p));
         for (int k = 0; k < 6; k++) begin
            adv();
            if (passed_b) npass_b++;
         end
      end
      for (int k = 0; k < 8; k++) begin
         adv();
         if (passed_b) npass_b++;
      end
      checks++; if (npass_b != 6) begin failures++; $display("FAIL sat_pulses got=%0d want=6", npass_b); end
      checks++; if (score_b !== 2'd3) begin failures++; $display("FAIL sat_score got=%0d want=3", score_b); end
      checks++; if (score_a !== 8'd6) begin failures++; $display("FAIL sat_wide_score got=%0d want=6", score_a); end
   endtask

   task automatic test_pause_reset();
      do_reset();
      run = 1'b0;
      pair = {G, H}; valid = 1'b1; step = 1'b1;
      cyc();
      valid = 1'b0;
      cyc();
      step = 1'b0;
      checks++; if (ifa.req !== 1'b0 || occ_a !== 8'h00) begin failures++; $display("FAIL pause_load got=req%b occ%b want=req0 occ00000000", ifa.req, occ_a); end
      run = 1'b1;
      adv();
      checks++; if (slots_a[0] !== G || occ_a !== 8'b0000_0001) begin failures++; $display("FAIL pause_head got=%h/%b want=%h/00000001", slots_a[0], occ_a, G); end
      run = 1'b0;
      adv(); adv();
      checks++; if (slots_a[0] !== G || slots_a[1] !== 24'h0 || occ_a !== 8'b0000_0001) begin failures++; $display("FAIL pause_frozen got=%h,%h/%b want=%h,0/00000001", slots_a[1], slots_a[0], occ_a, G); end
      run = 1'b1;
      do_reset();
      checks++; if (slots_a !== '0 || occ_a !== 8'h00 || ifa.req !== 1'b1 || score_a !== 8'd0 || passed_a !== 1'b0) begin failures++; $display("FAIL tail_reset got=occ%b req%b s%0d p%b want=occ00000000 req1 s0 p0", occ_a, ifa.req, score_a, passed_a); end
      adv();
      checks++; if (occ_a !== 8'h00) begin failures++; $display("FAIL tail_reset_empty got=%b want=00000000", occ_a); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; run = 1'b1; step = 1'b0; valid = 1'b0; pair = '0;
      test_reset();
      test_insert();
      test_starve();
      test_pass();
      test_saturate();
      test_pause_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
